// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for async_fifo. Bursts of up to MAX_BURST
// beats per grant are enabled by defining FIFO_ARB_BURST_EN; otherwise one beat per grant.
module fifo_wr_arbiter #(
  parameter int DATA_SIZE = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                           w_clk,
  input  logic                           w_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           w_full,
  output logic                           w_en,
  output logic [DATA_SIZE-1:0]           w_data,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy
);

  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ must be at least 2");
  end
  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: MAX_BURST must be at least 1");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_owner;
  logic [IDW-1:0]   r_ptr;

  logic [IDW-1:0]       w_pick;
  logic                 w_any;
  logic                 w_grant;
  logic                 w_owner_valid;
  logic [DATA_SIZE-1:0] w_owner_data;
  logic                 w_xfer;
  logic                 w_last;

  // Index arithmetic modulo NUM_REQ without a divider (NUM_REQ need not be 2^n).
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                              input int unsigned   off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[IDW-1:0];
  endfunction

  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_any && req_valid[wrap_add(r_ptr, i)]) begin
        w_pick = wrap_add(r_ptr, i);
        w_any  = 1'b1;
      end
    end
  end

  assign w_owner_valid = req_valid[r_owner];
  assign w_owner_data  = req_data[r_owner*DATA_SIZE +: DATA_SIZE];
  assign w_grant       = (r_state == ST_GRANT) && !w_rst;
  assign w_xfer        = w_grant && w_owner_valid && !w_full;

`ifdef FIFO_ARB_BURST_EN
  localparam int BW = $clog2(MAX_BURST) + 1;
  logic [BW-1:0] r_beat;

  assign w_last = (r_beat == BW'(MAX_BURST - 1));

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_beat <= '0;
    end else if (r_state == ST_IDLE) begin
      r_beat <= '0;
    end else if (w_xfer && !w_last) begin
      r_beat <= r_beat + BW'(1);
    end
  end
`else
  assign w_last = 1'b1;
`endif

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner <= w_pick;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!w_owner_valid || (w_xfer && w_last)) begin
            r_ptr   <= wrap_add(r_owner, 1);
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_grant) req_ready[r_owner] = ~w_full;
  end

  assign w_en     = w_xfer;
  assign w_data   = w_grant ? w_owner_data : '0;
  assign grant_id = w_rst ? '0 : r_owner;
  assign busy     = w_grant;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (4 requesters, 8-bit data); expectations
// follow the FIFO_ARB_BURST_EN setting of the build.
module tb_fifo_wr_arbiter;

  logic        w_clk;
  logic        w_rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        w_full;
  logic        w_en;
  logic [7:0]  w_data;
  logic [1:0]  grant_id;
  logic        busy;

  int n_chk;
  int n_err;
  int cnt [4];

  fifo_wr_arbiter #(
    .DATA_SIZE (8),
    .NUM_REQ   (4),
    .MAX_BURST (4)
  ) dut (
    .w_clk     (w_clk),
    .w_rst     (w_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .w_full    (w_full),
    .w_en      (w_en),
    .w_data    (w_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester i presents i*16 + (number of beats already accepted from it).
  task automatic load_data();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(i*16 + cnt[i]);
  endtask

  // One clock cycle: drive inputs, check combinational outputs, then clock.
  task automatic step(input string tag, input logic [3:0] v, input logic f, input logic rst,
                      input logic e_en, input logic e_busy, input int e_id, input int e_data);
    logic [3:0] acc;
    logic [3:0] e_rdy;
    req_valid = v;
    w_full    = f;
    w_rst     = rst;
    #1;
    e_rdy = (e_busy && !f) ? 4'(1 << e_id) : 4'b0000;
    check({tag, ".w_en"},  32'(w_en),      32'(e_en));
    check({tag, ".busy"},  32'(busy),      32'(e_busy));
    check({tag, ".ready"}, 32'(req_ready), 32'(e_rdy));
    if (e_busy) check({tag, ".id"}, 32'(grant_id), 32'(e_id));
    if (e_en || !e_busy) check({tag, ".data"}, 32'(w_data), e_en ? 32'(e_data) : 32'd0);
    acc = req_valid & req_ready;
    @(posedge w_clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) cnt[i]++;
    load_data();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    load_data();
    w_rst     = 1'b1;
    req_valid = 4'b1111;
    w_full    = 1'b0;
    #1;

    step("rst0", 4'b1111, 0, 1, 0, 0, 0, 0);
    step("rst1", 4'b1111, 0, 1, 0, 0, 0, 0);
    step("rst2", 4'b1111, 0, 1, 0, 0, 0, 0);
    step("idle0", 4'b1111, 0, 0, 0, 0, 0, 0);

`ifdef FIFO_ARB_BURST_EN
    step("b0a", 4'b1111, 0, 0, 1, 1, 0, 'h00);
    step("b0b", 4'b1111, 0, 0, 1, 1, 0, 'h01);
    step("b0c", 4'b1111, 0, 0, 1, 1, 0, 'h02);
    step("b0d", 4'b1111, 0, 0, 1, 1, 0, 'h03);
    step("gap0", 4'b1111, 0, 0, 0, 0, 0, 0);
    step("b1a", 4'b1111, 0, 0, 1, 1, 1, 'h10);
    step("b1b", 4'b1111, 0, 0, 1, 1, 1, 'h11);
    step("b1c", 4'b1111, 0, 0, 1, 1, 1, 'h12);
    step("b1d", 4'b1111, 0, 0, 1, 1, 1, 'h13);
    step("gap1", 4'b1111, 0, 0, 0, 0, 0, 0);
    step("b2a", 4'b1111, 0, 0, 1, 1, 2, 'h20);
    step("b2b", 4'b1111, 0, 0, 1, 1, 2, 'h21);
    step("b2c", 4'b1111, 0, 0, 1, 1, 2, 'h22);
    step("b2d", 4'b1111, 0, 0, 1, 1, 2, 'h23);
    step("gap2", 4'b1111, 0, 0, 0, 0, 0, 0);
    step("b3a", 4'b1111, 0, 0, 1, 1, 3, 'h30);
    step("b3b", 4'b1111, 0, 0, 1, 1, 3, 'h31);
    step("b3c", 4'b1111, 0, 0, 1, 1, 3, 'h32);
    step("b3d", 4'b1111, 0, 0, 1, 1, 3, 'h33);
    step("gap3", 4'b1111, 0, 0, 0, 0, 0, 0);
    step("wrap0", 4'b1111, 0, 0, 1, 1, 0, 'h04);
    step("drop0", 4'b1110, 0, 0, 0, 1, 0, 0);
    step("gap4", 4'b1110, 0, 0, 0, 0, 0, 0);
    step("s1a", 4'b1110, 0, 0, 1, 1, 1, 'h14);
    step("s1b", 4'b1110, 0, 0, 1, 1, 1, 'h15);
    step("full0", 4'b1110, 1, 0, 0, 1, 1, 0);
    step("full1", 4'b1110, 1, 0, 0, 1, 1, 0);
    step("full2", 4'b1110, 1, 0, 0, 1, 1, 0);
    step("s1c", 4'b1110, 0, 0, 1, 1, 1, 'h16);
    step("lastfull", 4'b1110, 1, 0, 0, 1, 1, 0);
    step("s1d", 4'b1110, 0, 0, 1, 1, 1, 'h17);
    step("gap5", 4'b1100, 0, 0, 0, 0, 0, 0);
    step("d2a", 4'b1100, 0, 0, 1, 1, 2, 'h24);
    step("d2b", 4'b1100, 0, 0, 1, 1, 2, 'h25);
    step("drop2", 4'b1000, 0, 0, 0, 1, 2, 0);
    step("gap6", 4'b1000, 0, 0, 0, 0, 0, 0);
    step("d3a", 4'b1000, 0, 0, 1, 1, 3, 'h34);
    step("drop3", 4'b0100, 0, 0, 0, 1, 3, 0);
    step("gap7", 4'b0100, 0, 0, 0, 0, 0, 0);
    step("m2a", 4'b0100, 0, 0, 1, 1, 2, 'h26);
    step("rstmid", 4'b1111, 0, 1, 0, 0, 0, 0);
    step("gap8", 4'b1110, 0, 0, 0, 0, 0, 0);
    step("post1", 4'b1110, 0, 0, 1, 1, 1, 'h18);
`else
    step("g0", 4'b1111, 0, 0, 1, 1, 0, 'h00);
    step("gap0", 4'b1111, 0, 0, 0, 0, 0, 0);
    step("g1", 4'b1111, 0, 0, 1, 1, 1, 'h10);
    step("gap1", 4'b1111, 0, 0, 0, 0, 0, 0);
    step("g2", 4'b1111, 0, 0, 1, 1, 2, 'h20);
    step("gap2", 4'b1111, 0, 0, 0, 0, 0, 0);
    step("g3", 4'b1111, 0, 0, 1, 1, 3, 'h30);
    step("gap3", 4'b1111, 0, 0, 0, 0, 0, 0);
    step("wrap0", 4'b1111, 0, 0, 1, 1, 0, 'h01);
    step("gap4", 4'b1111, 0, 0, 0, 0, 0, 0);
    step("full0", 4'b1111, 1, 0, 0, 1, 1, 0);
    step("full1", 4'b1111, 1, 0, 0, 1, 1, 0);
    step("g1b", 4'b1111, 0, 0, 1, 1, 1, 'h11);
    step("gap5", 4'b1111, 0, 0, 0, 0, 0, 0);
    step("drop2", 4'b1011, 0, 0, 0, 1, 2, 0);
    step("gap6", 4'b1011, 0, 0, 0, 0, 0, 0);
    step("rstmid", 4'b1111, 0, 1, 0, 0, 0, 0);
    step("gap7", 4'b1100, 0, 0, 0, 0, 0, 0);
    step("g2b", 4'b1100, 0, 0, 1, 1, 2, 'h21);
    step("gap8", 4'b1100, 0, 0, 0, 0, 0, 0);
    step("g3b", 4'b1100, 0, 0, 1, 1, 3, 'h31);
`endif
    step("quiet0", 4'b0000, 0, 0, 0, 0, 0, 0);
    step("quiet1", 4'b0000, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter for the `async_fifo` write port. It shares the single FIFO write interface among `NUM_REQ` requesters in the `w_clk` domain using round-robin grants with bounded bursts. It gates every write on `w_full`, so no requester can overflow the FIFO. It sits between the producer blocks and the `w_en`/`w_data`/`w_full` ports of `async_fifo`.

## Interface
- `DATA_SIZE`, default 8: data width; must match the `async_fifo` `DATA_SIZE`.
- `NUM_REQ`, default 4: number of requesters, ≥2; need not be a power of two.
- `MAX_BURST`, default 4: maximum beats per grant, ≥1; only used when `FIFO_ARB_BURST_EN` is defined.

Ports:
- `w_clk`  in  1  write-domain clock.
- `w_rst`  in  1  reset; synchronous and active-high.
- `req_valid`  in  `NUM_REQ`  per-requester data valid.
- `req_data`  in  `NUM_REQ*DATA_SIZE`  requester i occupies `[i*DATA_SIZE +: DATA_SIZE]`.
- `req_ready`  out  `NUM_REQ`  per-requester accept; at most one bit high.
- `w_full`  in  1  FIFO full flag.
- `w_en`  out  1  FIFO write enable.
- `w_data`  out  `DATA_SIZE`  FIFO write data.
- `grant_id`  out  `$clog2(NUM_REQ)`  current owner index; valid while `busy`=1.
- `busy`  out  1  high in state GRANT.

## Operation
- **Registered state:**
  - `state` ∈ {IDLE, GRANT}.
  - `owner` drives `grant_id`.
  - `ptr` is the round-robin start index.
  - `beat` is a burst counter of width `$clog2(MAX_BURST)+1`.
- **IDLE:**
  - `req_ready`=0 and `w_en`=0.
  - If any `req_valid` bit is set: `owner` ← first set index searching `ptr`, `ptr+1`, … with wrap from `NUM_REQ-1` to 0; `beat` ← 0; go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT (combinational outputs):**
  - `req_ready[owner]` = `~w_full`.
  - `w_en` = `req_valid[owner] & ~w_full`.
  - `w_data` = `req_data[owner]`.
  - A transfer occurs when `w_en`=1.
- **GRANT (release):** on a transfer with `beat == MAX_BURST-1`, or in any cycle with `req_valid[owner]`=0:
  - `ptr` ← `owner+1` mod `NUM_REQ`.
  - Go to IDLE.
- **GRANT (otherwise):** on a transfer, `beat` increments.
- **`w_full` stall:** no transfer; `beat` and `owner` hold. There is no timeout, so the owner waits as long as `w_full` stays high.
- **Data stability:** a requester must hold `req_data` stable while `req_valid & ~req_ready`. It may drop `req_valid` at any time; the drop releases the grant.
- **Outputs outside GRANT:** `w_data` = 0.

## Timing
- **Reset:**
  - `state`=IDLE, `ptr`=0, `owner`=0, `beat`=0.
  - `w_en`, `req_ready`, `busy`, `w_data` = 0.
  - All outputs are gated by `~w_rst`, so they are 0 in every cycle `w_rst`=1, including mid-burst. No write is issued in a reset cycle.
- **Arbitration latency:** 1 cycle. A request seen in IDLE at edge n gives the first possible `w_en` in cycle n+1.
- **Throughput:** up to `MAX_BURST` beats in `MAX_BURST` consecutive cycles, then 1 IDLE bubble per grant.
- **Last-beat stall:** if `w_full` rises on the last beat, no transfer occurs; the burst finishes after `w_full` falls.
- **Simultaneous release and new request:** the releasing requester has lowest priority at the next arbitration. A requester that was never granted gets at most `NUM_REQ-1` grants ahead of it.
- **Drop on the final beat:** a valid drop in the same cycle that would have been the final beat means no transfer; the grant is released normally.

## Configuration
- Macro `FIFO_ARB_BURST_EN`.
  - **Defined:** grants last up to `MAX_BURST` beats as described above.
  - **Undefined:** `MAX_BURST` is ignored and treated as 1. Every transfer releases the grant, so the pattern is 1 write then 1 IDLE cycle per grant. The `beat` logic is compiled out.

## Test plan
- **Reset:** `w_rst`=1 for 3 cycles with `req_valid`=4'b1111 → `w_en`=0, `req_ready`=0, `busy`=0 throughout. After release: 1 IDLE cycle, then `grant_id`=0 and `w_en`=1.
- **Round robin with burst:** `FIFO_ARB_BURST_EN` defined, `MAX_BURST`=4, all four requesters continuously valid, `w_full`=0 → `grant_id` sequence 0,1,2,3,0. `w_en` pattern is 4 high, 1 low, repeating. The FIFO receives each requester's data in order.
- **Full stall:** owner 1 completes 2 beats, then `w_full`=1 for 3 cycles → `w_en`=0 and `req_ready`=0 for those cycles; `grant_id` stays 1. Exactly 2 more beats follow after `w_full` falls, with no data lost or duplicated.
- **Requester drop:** only requesters 2 and 3 valid; requester 2 drops `req_valid` after 2 beats → release, 1 IDLE cycle, then `grant_id`=3.
- **Macro off:** all four requesters valid → `grant_id` advances every write: 0,1,2,3,0. `w_en` alternates high and low.
- **Reset mid-burst:** `w_rst` pulsed during owner 2's second beat → `w_en`=0 in that cycle. Afterwards `ptr`=0, and the next grant goes to the lowest valid index.
